// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, press/release pulses.
// Define BTN_LONG_PRESS_EN to add a hold counter and the long_press_pulse output.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter bit BTN_ACTIVE_LOW    = 1'b1,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst_async_n,
    input  logic btn_raw,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
`ifdef BTN_LONG_PRESS_EN
    ,
    output logic long_press_pulse
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic IDLE_LVL = BTN_ACTIVE_LOW;

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_DEB_PRESS,
        ST_PRESSED,
        ST_DEB_RELEASE
    } state_t;

    // Parameter sanity is enforced at elaboration so a bad build never reaches hardware.
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
    end

    logic             sync1_q;
    logic             sync2_q;
    logic             btn_act;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pressed_q, pressed_d;
    logic             press_pulse_q, press_pulse_d;
    logic             release_pulse_q, release_pulse_d;

    // Normalised so that 1 always means "button held" regardless of board wiring.
    assign btn_act = sync2_q ^ BTN_ACTIVE_LOW;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (btn_act) begin
                    state_d = ST_DEB_PRESS;
                    cnt_d   = '0;
                end
            end
            ST_DEB_PRESS: begin
                if (!btn_act) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = ST_PRESSED;
                    cnt_d         = '0;
                    press_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!btn_act) begin
                    state_d = ST_DEB_RELEASE;
                    cnt_d   = '0;
                end
            end
            ST_DEB_RELEASE: begin
                if (btn_act) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d         = ST_RELEASED;
                    cnt_d           = '0;
                    release_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase
        pressed_d = (state_d == ST_PRESSED) || (state_d == ST_DEB_RELEASE);
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_PRESS_CYCLES - 2);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_pulse_q, long_pulse_d;

    // Saturating at HOLD_LAST guarantees a single long pulse per accepted press.
    always_comb begin
        hold_d       = hold_q;
        long_pulse_d = 1'b0;
        if (press_pulse_d) begin
            hold_d = '0;
        end else if (((state_q == ST_PRESSED) || (state_q == ST_DEB_RELEASE)) &&
                     (hold_q != HOLD_LAST)) begin
            hold_d       = hold_q + HOLD_W'(1);
            long_pulse_d = (hold_q == HOLD_PRE);
        end
    end

    assign long_press_pulse = long_pulse_q;
`endif

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            sync1_q         <= IDLE_LVL;
            sync2_q         <= IDLE_LVL;
            state_q         <= ST_RELEASED;
            cnt_q           <= '0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
            hold_q          <= '0;
            long_pulse_q    <= 1'b0;
`endif
        end else begin
            sync1_q         <= btn_raw;
            sync2_q         <= sync1_q;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
`ifdef BTN_LONG_PRESS_EN
            hold_q          <= hold_d;
            long_pulse_q    <= long_pulse_d;
`endif
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: run-length reference model checked every
// cycle, plus hand-computed latency checks (DEBOUNCE=4 -> 7 edges, LONG=20 -> 19 edges).
module tb_button_debouncer;

    localparam int D = 4;
    localparam int L = 20;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic btn_raw = 1'b1;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
`ifdef BTN_LONG_PRESS_EN
    logic long_press_pulse;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    button_debouncer #(
        .DEBOUNCE_CYCLES  (D),
        .BTN_ACTIVE_LOW   (1'b1),
        .LONG_PRESS_CYCLES(L)
    ) dut (
        .clk          (clk),
        .rst_async_n  (rst_n),
        .btn_raw      (btn_raw),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
`ifdef BTN_LONG_PRESS_EN
        ,
        .long_press_pulse(long_press_pulse)
`endif
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a level flips once D+1 consecutive synchronized samples disagree with it.
    logic m_raw1 = 1'b1, m_raw2 = 1'b1;
    logic m_level = 1'b0, m_press = 1'b0, m_rel = 1'b0, m_long = 1'b0;
    int   m_run = 0, m_hold = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_raw1 = 1'b1; m_raw2 = 1'b1;
                m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
                m_run = 0; m_hold = 0;
            end else begin
                logic act;
                act     = !m_raw2;
                m_press = 1'b0;
                m_rel   = 1'b0;
                m_long  = 1'b0;
                if (m_level && m_hold < L - 1) begin
                    m_hold = m_hold + 1;
                    if (m_hold == L - 1) m_long = 1'b1;
                end
                if (act != m_level) begin
                    m_run = m_run + 1;
                    if (m_run == D + 1) begin
                        m_level = act;
                        m_run   = 0;
                        if (act) begin
                            m_press = 1'b1;
                            m_hold  = 0;
                        end else begin
                            m_rel = 1'b1;
                        end
                    end
                end else begin
                    m_run = 0;
                end
                m_raw2 = m_raw1;
                m_raw1 = btn_raw;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if (pressed !== m_level) begin
                errors++;
                $display("FAIL pressed @%0d: got %b, expected %b", cyc, pressed, m_level);
            end
            checks++;
            if (press_pulse !== m_press) begin
                errors++;
                $display("FAIL press_pulse @%0d: got %b, expected %b", cyc, press_pulse, m_press);
            end
            checks++;
            if (release_pulse !== m_rel) begin
                errors++;
                $display("FAIL release_pulse @%0d: got %b, expected %b", cyc, release_pulse, m_rel);
            end
            checks++;
            if (press_pulse && release_pulse) begin
                errors++;
                $display("FAIL pulse_exclusive @%0d: got both pulses, expected at most one", cyc);
            end
`ifdef BTN_LONG_PRESS_EN
            checks++;
            if (long_press_pulse !== m_long) begin
                errors++;
                $display("FAIL long_press_pulse @%0d: got %b, expected %b", cyc, long_press_pulse, m_long);
            end
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic pulse_of(input int which);
        logic v;
        v = 1'b0;
        case (which)
            0: v = press_pulse;
            1: v = release_pulse;
`ifdef BTN_LONG_PRESS_EN
            2: v = long_press_pulse;
`endif
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    // Waits (bounded) for the chosen pulse and checks its edge offset from t0.
    task automatic wait_pulse(input int which, input int t0, input int lat,
                              input string name, output int seen);
        bit found;
        found = 1'b0;
        seen  = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (pulse_of(which)) begin
                found = 1'b1;
                seen  = cyc;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: got no pulse within 40 cycles, expected one at +%0d edges", name, lat);
        end else if (seen - t0 != lat) begin
            errors++;
            $display("FAIL %s: got pulse at +%0d edges, expected +%0d", name, seen - t0, lat);
        end else begin
            $display("%s: pulse at +%0d edges", name, seen - t0);
        end
    endtask

    task automatic check_lit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end else begin
            $display("%s: %b", name, got);
        end
    endtask

    initial begin
        int t0;
        int seen;
        int stray;

        // Reset with button idle, released at a mid-cycle offset.
        step(3);
        #7 rst_n = 1'b1;
        step(1);
        check_lit("reset_pressed", pressed, 1'b0);
        check_lit("reset_press_pulse", press_pulse, 1'b0);
        check_lit("reset_release_pulse", release_pulse, 1'b0);
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (press_pulse || release_pulse) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL idle_no_pulse: got %0d pulses, expected 0", stray);
        end else begin
            $display("idle_no_pulse: 0 pulses over 20 cycles");
        end

        // Clean press.
        btn_raw = 1'b0; t0 = cyc;
        wait_pulse(0, t0, 7, "clean_press", seen);
        step(3);
        check_lit("clean_press_level", pressed, 1'b1);

        // Clean release; pressed falls on the release edge.
        btn_raw = 1'b1; t0 = cyc;
        wait_pulse(1, t0, 7, "clean_release", seen);
        check_lit("release_level", pressed, 1'b0);
        step(5);

        // Bouncy press: 0 x3, 1 x1, then 0 held.
        btn_raw = 1'b0; step(3);
        btn_raw = 1'b1; step(1);
        btn_raw = 1'b0; t0 = cyc;
        wait_pulse(0, t0, 7, "bounce_press", seen);
        step(3);

        // Release with a 2-cycle glitch back to pressed.
        btn_raw = 1'b1; step(3);
        btn_raw = 1'b0; step(2);
        btn_raw = 1'b1; t0 = cyc;
        wait_pulse(1, t0, 7, "glitch_release", seen);
        step(5);

        // Bounce exactly at the last debounce count: 0 x4, 1 x1, then 0 held.
        btn_raw = 1'b0; step(4);
        btn_raw = 1'b1; step(1);
        btn_raw = 1'b0; t0 = cyc;
        wait_pulse(0, t0, 7, "boundary_bounce_press", seen);
        step(4);

        // Asynchronous reset while held, then deassert with the button still down.
        check_lit("pre_reset_level", pressed, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check_lit("async_reset_pressed", pressed, 1'b0);
        check_lit("async_reset_release_pulse", release_pulse, 1'b0);
        step(2);
        #5 rst_n = 1'b1; t0 = cyc;
        wait_pulse(0, t0, 7, "press_after_reset", seen);

`ifdef BTN_LONG_PRESS_EN
        // Long press with a 2-cycle release glitch inside the hold window.
        t0 = seen;
        step(3);
        btn_raw = 1'b1; step(2);
        btn_raw = 1'b0;
        wait_pulse(2, t0, 19, "long_press", seen);
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (long_press_pulse) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL long_press_once: got %0d extra long pulses, expected 0", stray);
        end else begin
            $display("long_press_once: no extra long pulses");
        end
`else
        step(10);
`endif

        btn_raw = 1'b1; t0 = cyc;
        wait_pulse(1, t0, 7, "final_release", seen);
        step(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
